// File: rtl/pause_ctrl.sv
// PAUSE instruction sequencer: stalls fetch/decode, drains the back end,
// waits a programmable number of cycles, then retires the PAUSE as a bubble.
module pause_ctrl #(
    parameter int DRAIN_STAGES = 3,
    parameter int LEN_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic                    id_pause,
    input  logic [LEN_W-1:0]        id_len,
    input  logic                    flush,
    input  logic [DRAIN_STAGES-1:0] stage_valid,
    input  logic                    mem_busy,
    output logic                    stall_fd,
    output logic                    bubble_ex,
    output logic                    pause_retire,
    output logic                    busy,
    output logic [31:0]             pause_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        WAIT,
        DONE
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   cnt_d;
    logic [31:0]        pause_count_q;
    logic [31:0]        pause_count_d;
    logic               start;
    logic               drained;
    logic               in_seq;

    assign start         = id_valid & id_pause & ~flush;
    assign drained       = ~(|stage_valid) & ~mem_busy;
    assign cnt_d         = cnt_q - 1'b1;
    assign pause_count_d = pause_count_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pause_count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= DRAIN;
                        cnt_q   <= id_len;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (drained) begin
                        state_q <= (cnt_q != '0) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The PAUSE has completed, so a late flush cannot cancel it.
                    pause_count_q <= pause_count_d;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_seq       = (state_q == DRAIN) | (state_q == WAIT);
    assign stall_fd     = ((state_q == IDLE) & start) | (in_seq & ~flush);
    assign bubble_ex    = stall_fd | (state_q == DONE);
    assign pause_retire = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign pause_count  = pause_count_q;

endmodule

// File: tb/tb_pause_ctrl.sv
// Scoreboard bench for pause_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_pause_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_pause;
    logic [7:0]  id_len;
    logic        flush;
    logic [2:0]  stage_valid;
    logic        mem_busy;
    logic        stall_fd;
    logic        bubble_ex;
    logic        pause_retire;
    logic        busy;
    logic [31:0] pause_count;

    typedef struct {
        logic        stall;
        logic        bubble;
        logic        retire;
        logic        busy;
        logic [31:0] count;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;

    pause_ctrl #(.DRAIN_STAGES(3), .LEN_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_pause    (id_pause),
        .id_len      (id_len),
        .flush       (flush),
        .stage_valid (stage_valid),
        .mem_busy    (mem_busy),
        .stall_fd    (stall_fd),
        .bubble_ex   (bubble_ex),
        .pause_retire(pause_retire),
        .busy        (busy),
        .pause_count (pause_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input string fld,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.tag, "stall_fd", {31'd0, stall_fd}, {31'd0, e.stall});
            check(e.tag, "bubble_ex", {31'd0, bubble_ex}, {31'd0, e.bubble});
            check(e.tag, "retire", {31'd0, pause_retire}, {31'd0, e.retire});
            check(e.tag, "busy", {31'd0, busy}, {31'd0, e.busy});
            check(e.tag, "count", pause_count, e.count);
        end
    end

    task automatic push(input string tag, input logic es, input logic eb,
                        input logic er, input logic ey, input logic [31:0] ec);
        exp_t e;
        e.stall  = es;
        e.bubble = eb;
        e.retire = er;
        e.busy   = ey;
        e.count  = ec;
        e.tag    = tag;
        q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic p, input logic [7:0] l,
                         input logic f, input logic [2:0] sv, input logic mb);
        id_valid    = v;
        id_pause    = p;
        id_len      = l;
        flush       = f;
        stage_valid = sv;
        mem_busy    = mb;
    endtask

    task automatic cyc(input string tag,
                       input logic v, input logic p, input logic [7:0] l,
                       input logic f, input logic [2:0] sv, input logic mb,
                       input logic es, input logic eb, input logic er,
                       input logic ey, input logic [31:0] ec);
        @(posedge clk);
        #1;
        drive(v, p, l, f, sv, mb);
        push(tag, es, eb, er, ey, ec);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1, 1, 8'd0, 0, 3'b000, 0);

        // reset with a PAUSE in decode; release makes that cycle cycle 0
        cyc("rst0", 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc("rst1", 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc("l0_drain", 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        cyc("l0_done", 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        cyc("l0_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // len 5: retire in cycle 7; later id_len changes must be ignored
        cyc("l5_c0", 1, 1, 5, 0, 0, 0, 1, 1, 0, 0, 1);
        cyc("l5_c1", 1, 1, 9, 0, 0, 0, 1, 1, 0, 1, 1);
        for (int i = 2; i <= 6; i++)
            cyc("l5_wait", 1, 1, 9, 0, 0, 0, 1, 1, 0, 1, 1);
        cyc("l5_done", 1, 1, 9, 0, 0, 0, 0, 1, 1, 1, 1);
        cyc("l5_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

        // drain holds while stages or memory are busy
        cyc("dr_c0", 1, 1, 1, 0, 3'b111, 1, 1, 1, 0, 0, 2);
        cyc("dr_c1", 1, 1, 1, 0, 3'b110, 1, 1, 1, 0, 1, 2);
        cyc("dr_c2", 1, 1, 1, 0, 3'b100, 1, 1, 1, 0, 1, 2);
        cyc("dr_c3", 1, 1, 1, 0, 3'b000, 1, 1, 1, 0, 1, 2);
        cyc("dr_c4", 1, 1, 1, 0, 3'b000, 0, 1, 1, 0, 1, 2);
        cyc("dr_wait", 1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 2);
        cyc("dr_done", 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 2);
        cyc("dr_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);

        // flush in WAIT with cnt=3, then flush alongside start in IDLE
        cyc("fl_c0", 1, 1, 5, 0, 0, 0, 1, 1, 0, 0, 3);
        cyc("fl_c1", 1, 1, 5, 0, 0, 0, 1, 1, 0, 1, 3);
        cyc("fl_c2", 1, 1, 5, 0, 0, 0, 1, 1, 0, 1, 3);
        cyc("fl_c3", 1, 1, 5, 0, 0, 0, 1, 1, 0, 1, 3);
        cyc("fl_wait", 1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 3);
        cyc("fl_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        cyc("fl_start", 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 3);
        cyc("fl_stay", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);

        // back-to-back len 0; flush in the second DONE still retires
        cyc("bb_c0", 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 3);
        cyc("bb_c1", 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 3);
        cyc("bb_done1", 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 3);
        cyc("bb_c3", 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 4);
        cyc("bb_c4", 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 4);
        cyc("bb_done2", 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 4);
        cyc("novalid", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        cyc("novalid2", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5);

        // counter wrap
        @(posedge clk);
        #1 force dut.pause_count_q = 32'hFFFF_FFFF;
        #2 release dut.pause_count_q;
        cyc("wr_c0", 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 32'hFFFF_FFFF);
        cyc("wr_c1", 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 32'hFFFF_FFFF);
        cyc("wr_done", 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 32'hFFFF_FFFF);
        cyc("wr_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("wr_c4", 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc("wr_c5", 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        cyc("wr_done2", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        cyc("wr_one", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // asynchronous reset during DRAIN
        cyc("ar_c0", 1, 1, 2, 0, 3'b001, 0, 1, 1, 0, 0, 1);
        @(posedge clk);
        #1 drive(1, 1, 2, 0, 3'b001, 0);
        #1 rst_n = 1'b0;
        push("ar_rst", 1, 1, 0, 0, 0);
        cyc("ar_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc("ar_post", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("ar_post2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pause_ctrl.md
# pause_ctrl

Sequencer for the pipeline's PAUSE instruction. It sits beside decode and consumes the decoder's `pause` flag. On a PAUSE it stalls fetch/decode, injects bubbles into execute until every downstream stage and the memory port are empty, waits a programmable number of extra cycles, then retires the PAUSE as a bubble. It also keeps a retired-PAUSE performance counter.

## Interface
- `DRAIN_STAGES`, default 3: number of downstream stages (EX, MEM, WB) whose valid bits must clear.
- `LEN_W`, default 8: width of the extra-wait length field.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: decode holds a valid instruction.
- `id_pause` in 1: decoder `pause` flag for that instruction.
- `id_len` in LEN_W: extra wait cycles, taken from the PAUSE immediate.
- `flush` in 1: redirect from a later stage that kills the decode instruction.
- `stage_valid` in DRAIN_STAGES: valid bits of the EX..WB stages.
- `mem_busy` in 1: data-memory store or load still outstanding.
- `stall_fd` out 1: hold PC and the IF/ID register.
- `bubble_ex` out 1: load a NOP into ID/EX instead of the decode instruction.
- `pause_retire` out 1: one-cycle pulse when the PAUSE completes.
- `busy` out 1: FSM is not IDLE.
- `pause_count` out 32: number of retired PAUSEs.

## Operation
- FSM states: IDLE, DRAIN, WAIT, DONE. Registers: `state`, `cnt` (LEN_W), `pause_count` (32).
- `start` = `id_valid & id_pause & ~flush`.
- IDLE:
  - On `start`: go to DRAIN and latch `cnt <= id_len`.
  - Otherwise stay in IDLE.
- DRAIN:
  - Stay while `|stage_valid | mem_busy`.
  - Once both are clear: go to WAIT if `cnt != 0`, else go to DONE.
- WAIT:
  - Each cycle, `cnt <= cnt - 1`.
  - Go to DONE in the cycle `cnt == 1`, so WAIT lasts exactly `id_len` cycles.
- DONE:
  - Assert `pause_retire`.
  - Increment `pause_count`; it wraps from 0xFFFF_FFFF to 0.
  - Go to IDLE unconditionally.
- `flush` in DRAIN or WAIT:
  - Go to IDLE next cycle.
  - No retire, no count increment, `cnt` is don't-care.
- `flush` in DONE: retire still occurs, because the PAUSE has already completed.
- Outputs (combinational from state and inputs):
  - `stall_fd = (state==IDLE & start) | (state==DRAIN) | (state==WAIT)`, each term gated by `~flush` in DRAIN/WAIT.
  - `bubble_ex = stall_fd | (state==DONE)`. The PAUSE never enters EX.
  - In DONE, `stall_fd = 0`, so the PAUSE in decode is overwritten by the next fetch.
  - `busy = (state != IDLE)`.
- A PAUSE arriving in decode the cycle right after DONE starts a new sequence normally (back-to-back PAUSEs).
- `id_pause` without `id_valid` is ignored.
- `id_len` is sampled only on the IDLE→DRAIN transition.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `state = IDLE`, `cnt = 0`, `pause_count = 0`.
  - `busy = 0`, `pause_retire = 0`.
  - `stall_fd` and `bubble_ex` = 0 unless `start` is high.
- Reset mid-sequence aborts immediately, with no retire.
- DRAIN is always at least 1 cycle.
- Empty pipeline, `id_len = L`:
  - Detect in cycle 0 (IDLE, stall).
  - DRAIN in cycle 1.
  - WAIT in cycles 2..L+1.
  - DONE and retire in cycle L+2.
  - `stall_fd` is high in cycles 0..L+1.
- If the pipeline holds k valid stages on entry, DRAIN adds up to `max(k, mem_busy duration)` cycles. The bubbles guarantee drain within DRAIN_STAGES cycles when `mem_busy` is low.
- Inputs are sampled at the rising edge. `pause_count` updates at the edge that leaves DONE.

## Test plan
- Reset with PAUSE present → all registers 0; after release, `id_valid=1, id_pause=1, id_len=0`, pipeline empty → `stall_fd` high in cycles 0–1, `pause_retire` in cycle 2, `pause_count=1`.
- `id_len=5`, empty pipeline → `pause_retire` exactly in cycle 7; `stall_fd` high in cycles 0–6; `bubble_ex` high in cycles 0–7.
- `stage_valid=3'b111`, clearing one stage per cycle, plus `mem_busy` high for 4 cycles → DRAIN holds until both are clear, then WAIT/DONE follow as specified.
- `flush` asserted in WAIT with `cnt=3` → IDLE next cycle, no `pause_retire`, `pause_count` unchanged, `stall_fd=0`. `flush` together with `start` in IDLE → no transition.
- Two back-to-back PAUSEs with `id_len=0` → two retire pulses 3 cycles apart, `pause_count=2`. Preload `pause_count=0xFFFF_FFFF` via 2^32 retires (or force) → wraps to 0.
- `rst_n` pulsed low during DRAIN → `busy=0` immediately (asynchronous), no retire, `pause_count` cleared.
